// File: rtl/core_mem_pkg.sv
// Shared encodings and helpers for the core memory responder.
// Optional random stall insertion is controlled by CORE_MEM_RAND_STALL_EN in core_mem_responder.
package core_mem_pkg;

   localparam logic [2:0] SIZE_B = 3'b000;
   localparam logic [2:0] SIZE_H = 3'b010;
   localparam logic [2:0] SIZE_W = 3'b100;

   localparam int COP_WR = 0;
   localparam int COP_NC = 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // Unknown size encodings fall back to a full-word write.
   function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
      case (size)
         SIZE_B:  byte_en = 4'b0001 << addr_lo;
         SIZE_H:  byte_en = 4'b0011 << {addr_lo[1], 1'b0};
         default: byte_en = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/core_mem_port_fsm.sv
// Per-port request sequencer: accept, count down the latency, issue a one-cycle ack.
//   state   | meaning
//   IDLE    | waiting for val; accept pulses when val is seen here
//   WAIT    | counting down remaining latency cycles
//   ACK     | ack asserted for this single cycle
module core_mem_port_fsm
   import core_mem_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       val,
   input  logic [1:0] extra_wait,
   output logic       accept,
   output logic       ack
);

   logic [1:0] state;
   logic [4:0] cnt;
   logic [4:0] load_cnt;

   assign load_cnt = 5'(LATENCY - 1) + {3'b000, extra_wait};
   assign accept   = (state == ST_IDLE) && val;
   // Reset landing on the ACK cycle must suppress the ack as well.
   assign ack      = (state == ST_ACK) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (val) begin
                  cnt   <= load_cnt;
                  state <= (load_cnt == 5'd0) ? ST_ACK : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 5'd1;
               if (cnt <= 5'd1) state <= ST_ACK;
            end
            ST_ACK:  state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/core_mem_responder.sv
// Word-addressed backing memory answering the core's instruction and data request ports.
// Define CORE_MEM_RAND_STALL_EN to add 0..3 LFSR-chosen wait cycles per transaction.
module core_mem_responder
   import core_mem_pkg::*;
#(
   parameter int ADDR_W    = 14,
   parameter int I_LATENCY = 1,
   parameter int D_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_req_val,
   input  logic [31:0] i_req_addr,
   output logic        i_req_ack,
   output logic [31:0] i_ack_rdata,
   input  logic        d_req_val,
   input  logic [31:0] d_req_addr,
   input  logic [2:0]  d_req_cop,
   input  logic [31:0] d_req_wdata,
   input  logic [2:0]  d_req_size,
   output logic        d_req_ack,
   output logic [31:0] d_ack_rdata
);

   logic [31:0]       mem [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] i_idx;
   logic [ADDR_W-1:0] d_idx;
   logic              d_wr;
   logic [3:0]        d_be;
   logic [31:0]       d_wdata_q;
   logic              i_accept;
   logic              d_accept;
   logic [1:0]        i_extra;
   logic [1:0]        d_extra;
   logic              unused_bits;

   assign unused_bits = ^{i_req_addr[31:ADDR_W+2], i_req_addr[1:0],
                          d_req_addr[31:ADDR_W+2], d_req_cop[2:1]};

`ifdef CORE_MEM_RAND_STALL_EN
   // Galois LFSR, x^16+x^14+x^13+x^11+1, shifting right.
   logic [15:0] lfsr;
   always_ff @(posedge clk) begin
      if (reset) lfsr <= 16'hACE1;
      else       lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end
   assign i_extra = lfsr[1:0];
   assign d_extra = lfsr[3:2];
`else
   assign i_extra = 2'b00;
   assign d_extra = 2'b00;
`endif

   core_mem_port_fsm #(.LATENCY(I_LATENCY)) u_i_fsm (
      .clk        (clk),
      .reset      (reset),
      .val        (i_req_val),
      .extra_wait (i_extra),
      .accept     (i_accept),
      .ack        (i_req_ack)
   );

   core_mem_port_fsm #(.LATENCY(D_LATENCY)) u_d_fsm (
      .clk        (clk),
      .reset      (reset),
      .val        (d_req_val),
      .extra_wait (d_extra),
      .accept     (d_accept),
      .ack        (d_req_ack)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         i_idx     <= '0;
         d_idx     <= '0;
         d_wr      <= 1'b0;
         d_be      <= 4'b0000;
         d_wdata_q <= '0;
      end else begin
         if (i_accept) i_idx <= i_req_addr[ADDR_W+1:2];
         if (d_accept) begin
            d_idx     <= d_req_addr[ADDR_W+1:2];
            d_wr      <= d_req_cop[COP_WR];
            d_be      <= byte_en(d_req_size, d_req_addr[1:0]);
            d_wdata_q <= d_req_wdata;
         end
      end
   end

   // Commit on the edge closing the data ack; reads in that same cycle see old data.
   always_ff @(posedge clk) begin
      if (!reset && d_req_ack && d_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (d_be[b]) mem[d_idx][8*b +: 8] <= d_wdata_q[8*b +: 8];
         end
      end
   end

   assign i_ack_rdata = i_req_ack ? mem[i_idx] : 32'h0;
   assign d_ack_rdata = (d_req_ack && !d_wr) ? mem[d_idx] : 32'h0;

endmodule

// File: tb/tb_core_mem_responder.sv
// Directed bench for core_mem_responder, with a small random read/write pass against a word model.
`define CHK(tag, obs, exp) \
   begin \
      checks++; \
      assert ((obs) === (exp)) else begin \
         failures++; \
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp); \
      end \
   end

module tb_core_mem_responder;

   localparam int I_LAT = 1;
   localparam int D_LAT = 2;
`ifdef CORE_MEM_RAND_STALL_EN
   localparam int EXTRA  = 3;
   localparam int N_RAND = 1000;
`else
   localparam int EXTRA  = 0;
   localparam int N_RAND = 60;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req_val;
   logic [31:0] i_req_addr;
   logic        i_req_ack;
   logic [31:0] i_ack_rdata;
   logic        d_req_val;
   logic [31:0] d_req_addr;
   logic [2:0]  d_req_cop;
   logic [31:0] d_req_wdata;
   logic [2:0]  d_req_size;
   logic        d_req_ack;
   logic [31:0] d_ack_rdata;

   int checks   = 0;
   int failures = 0;

   core_mem_responder #(.ADDR_W(14), .I_LATENCY(I_LAT), .D_LATENCY(D_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_req_val   (i_req_val),
      .i_req_addr  (i_req_addr),
      .i_req_ack   (i_req_ack),
      .i_ack_rdata (i_ack_rdata),
      .d_req_val   (d_req_val),
      .d_req_addr  (d_req_addr),
      .d_req_cop   (d_req_cop),
      .d_req_wdata (d_req_wdata),
      .d_req_size  (d_req_size),
      .d_req_ack   (d_req_ack),
      .d_ack_rdata (d_ack_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Called in an IDLE cycle (#1 after posedge); returns one cycle after the ack.
   task automatic d_xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output logic [31:0] rdata, output int lat);
      d_req_val   = 1'b1;
      d_req_addr  = addr;
      d_req_cop   = {2'b00, wr};
      d_req_wdata = wdata;
      d_req_size  = size;
      lat   = -1;
      rdata = 32'hxxxxxxxx;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (d_req_ack) begin
            lat   = n;
            rdata = d_ack_rdata;
            break;
         end
      end
      d_req_val = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic i_read(input logic [31:0] addr, output logic [31:0] rdata, output int lat);
      i_req_val  = 1'b1;
      i_req_addr = addr;
      lat   = -1;
      rdata = 32'hxxxxxxxx;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (i_req_ack) begin
            lat   = n;
            rdata = i_ack_rdata;
            break;
         end
      end
      i_req_val = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic chk_lat(input string tag, input int lat, input int nominal);
      checks++;
      assert (lat >= nominal && lat <= nominal + EXTRA) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d..%0d", tag, lat, nominal, nominal + EXTRA);
      end
   endtask

   function automatic logic [3:0] model_be(input logic [2:0] size, input logic [1:0] lo);
      if (size == 3'b000)      model_be = (lo == 2'd0) ? 4'b0001 : (lo == 2'd1) ? 4'b0010 :
                                          (lo == 2'd2) ? 4'b0100 : 4'b1000;
      else if (size == 3'b010) model_be = lo[1] ? 4'b1100 : 4'b0011;
      else                     model_be = 4'b1111;
   endfunction

   logic [31:0] rd;
   int          lat;
   logic [31:0] mdl [16];
   logic [31:0] t1_data [6];

   initial begin
      reset = 1'b1; i_req_val = 1'b0; i_req_addr = '0;
      d_req_val = 1'b0; d_req_addr = '0; d_req_cop = '0; d_req_wdata = '0; d_req_size = 3'b100;
      t1_data = '{32'd11, 32'd0, 32'd22, 32'd0, 32'd33, 32'd0};

      repeat (3) @(posedge clk);
      #1;
      `CHK("rst_i_ack",   i_req_ack,   1'b0)
      `CHK("rst_d_ack",   d_req_ack,   1'b0)
      `CHK("rst_i_rdata", i_ack_rdata, 32'h0)
      `CHK("rst_d_rdata", d_ack_rdata, 32'h0)
      reset = 1'b0;
      @(posedge clk); #1;

      d_xact(1'b1, 32'h0, 32'd11, 3'b100, rd, lat);
      `CHK("wr_ack_rdata_zero", rd, 32'h0)
      d_xact(1'b1, 32'h4, 32'd22, 3'b100, rd, lat);
      d_xact(1'b1, 32'h8, 32'd33, 3'b100, rd, lat);

`ifndef CORE_MEM_RAND_STALL_EN
      // Held i_req_val: acks every other cycle, address changed during each ack cycle
      i_req_val  = 1'b1;
      i_req_addr = 32'h0;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clk); #1;
         `CHK("tput_ack",   i_req_ack,   (c % 2 == 1) ? 1'b1 : 1'b0)
         `CHK("tput_rdata", i_ack_rdata, t1_data[c-1])
         if (c == 1) i_req_addr = 32'h4;
         if (c == 3) i_req_addr = 32'h8;
         if (c == 5) i_req_val  = 1'b0;
      end
      @(posedge clk); #1;
`endif

      d_xact(1'b1, 32'h10, 32'hDEADBEEF, 3'b100, rd, lat);
      `CHK("wword_rdata", rd, 32'h0)
      chk_lat("wword_lat", lat, D_LAT);
      d_xact(1'b0, 32'h10, 32'h0, 3'b100, rd, lat);
      `CHK("rword_data", rd, 32'hDEADBEEF)
      chk_lat("rword_lat", lat, D_LAT);

      d_xact(1'b1, 32'h10, 32'h11223344, 3'b100, rd, lat);
      d_xact(1'b1, 32'h13, 32'hAA000000, 3'b000, rd, lat);
      d_xact(1'b0, 32'h10, 32'h0, 3'b100, rd, lat);
      `CHK("byte_wr", rd, 32'hAA223344)
      d_xact(1'b1, 32'h12, 32'h55660000, 3'b010, rd, lat);
      d_xact(1'b0, 32'h10, 32'h0, 3'b100, rd, lat);
      `CHK("half_wr", rd, 32'h55663344)
      d_xact(1'b0, 32'h00010011, 32'h0, 3'b000, rd, lat);
      `CHK("alias_unshifted", rd, 32'h55663344)
      d_xact(1'b1, 32'h10, 32'h000000CC, 3'b000, rd, lat);
      i_read(32'h10, rd, lat);
      `CHK("iread_byte0", rd, 32'h556633CC)
      chk_lat("iread_lat", lat, I_LAT);
      d_xact(1'b1, 32'h14, 32'h00000077, 3'b000, rd, lat);
      d_xact(1'b1, 32'h16, 32'hCAFEF00D, 3'b111, rd, lat);
      d_xact(1'b0, 32'h14, 32'h0, 3'b100, rd, lat);
      `CHK("size_other_full", rd, 32'hCAFEF00D)

`ifndef CORE_MEM_RAND_STALL_EN
      // Instruction read and data write to one word acked together
      d_xact(1'b1, 32'h20, 32'h1, 3'b100, rd, lat);
      d_req_val = 1'b1; d_req_addr = 32'h20; d_req_cop = 3'b001;
      d_req_wdata = 32'h2; d_req_size = 3'b100;
      @(posedge clk); #1;
      `CHK("conf_d_wait", d_req_ack, 1'b0)
      i_req_val = 1'b1; i_req_addr = 32'h20;
      @(posedge clk); #1;
      `CHK("conf_i_ack",   i_req_ack,   1'b1)
      `CHK("conf_d_ack",   d_req_ack,   1'b1)
      `CHK("conf_i_old",   i_ack_rdata, 32'h1)
      `CHK("conf_d_rdata", d_ack_rdata, 32'h0)
      i_req_val = 1'b0; d_req_val = 1'b0;
      @(posedge clk); #1;
      i_read(32'h20, rd, lat);
      `CHK("conf_i_new", rd, 32'h2)

      // Reset during WAIT of a write
      d_xact(1'b1, 32'h30, 32'h5, 3'b100, rd, lat);
      d_req_val = 1'b1; d_req_addr = 32'h30; d_req_cop = 3'b001;
      d_req_wdata = 32'h99; d_req_size = 3'b100;
      @(posedge clk); #1;
      reset = 1'b1; d_req_val = 1'b0;
      @(posedge clk); #1;
      `CHK("rst_wait_noack", d_req_ack, 1'b0)
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         `CHK("rst_wait_quiet", d_req_ack, 1'b0)
      end
      d_xact(1'b0, 32'h30, 32'h0, 3'b100, rd, lat);
      `CHK("rst_wait_mem", rd, 32'h5)
      chk_lat("rst_wait_lat", lat, D_LAT);

      // Reset coinciding with the ACK cycle of a write
      d_req_val = 1'b1; d_req_addr = 32'h30; d_req_cop = 3'b001;
      d_req_wdata = 32'h77; d_req_size = 3'b100;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; d_req_val = 1'b0;
      #1;
      `CHK("rst_ack_noack", d_req_ack, 1'b0)
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      d_xact(1'b0, 32'h30, 32'h0, 3'b100, rd, lat);
      `CHK("rst_ack_mem", rd, 32'h5)
`endif

      // Random mixed traffic over 16 words at 0x100 against a word model
      for (int w = 0; w < 16; w++) begin
         mdl[w] = 32'h1000_0000 + 32'(w) * 32'h0101_0101;
         d_xact(1'b1, 32'h100 + 32'(w * 4), mdl[w], 3'b100, rd, lat);
      end
      for (int k = 0; k < N_RAND; k++) begin
         int          op;
         int          w;
         logic [1:0]  lo;
         logic [2:0]  sz;
         logic [31:0] wd;
         logic [3:0]  be;
         op = int'($urandom_range(0, 2));
         w  = int'($urandom_range(0, 15));
         lo = 2'($urandom_range(0, 3));
         if (op == 0) begin
            d_xact(1'b0, 32'h100 + 32'(w * 4) + 32'(lo), 32'h0, 3'b100, rd, lat);
            `CHK("rand_d_read", rd, mdl[w])
            chk_lat("rand_d_lat", lat, D_LAT);
         end else if (op == 1) begin
            i_read(32'h100 + 32'(w * 4), rd, lat);
            `CHK("rand_i_read", rd, mdl[w])
            chk_lat("rand_i_lat", lat, I_LAT);
         end else begin
            case ($urandom_range(0, 2))
               0:       sz = 3'b000;
               1:       sz = 3'b010;
               default: sz = 3'b100;
            endcase
            wd = $urandom;
            be = model_be(sz, lo);
            d_xact(1'b1, 32'h100 + 32'(w * 4) + 32'(lo), wd, sz, rd, lat);
            `CHK("rand_wr_rdata", rd, 32'h0)
            chk_lat("rand_wr_lat", lat, D_LAT);
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[w][8*b +: 8] = wd[8*b +: 8];
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
